// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair (piso and sipo).
// Holding-register states, bit-order selector strings and counter sizing.
package serdes_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  localparam string MSB_FIRST = "true";
  localparam string LSB_FIRST = "false";

  // Bit counter width; never narrower than one bit even for two-bit words.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo.sv
// Serial-in parallel-out deserializer: assembles DATA_WIDTH-bit words from a
// strobed serial stream and parks each finished word in a one-entry holding register.
module sipo
  import serdes_pkg::*;
#(
  parameter int    DATA_WIDTH   = 8,
  parameter string DO_MSB_FIRST = MSB_FIRST
) (
  input  logic                  i_clk,
  input  logic                  i_a_rst,
  input  logic                  i_sync,
  input  logic                  i_data_valid,
  input  logic                  i_data,
  input  logic                  i_rd_en,
  input  logic                  i_clr_ovf,
  output logic                  o_data_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_overflow
);

  localparam int            CW        = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_WIDTH - 1);
  localparam bit            MSB_ORDER = (DO_MSB_FIRST == MSB_FIRST);

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("sipo: DATA_WIDTH must be at least 2");
  end

  if ((DO_MSB_FIRST != MSB_FIRST) && (DO_MSB_FIRST != LSB_FIRST)) begin : g_bad_order
    $error("sipo: DO_MSB_FIRST must be \"true\" or \"false\"");
  end

  // MSB-first enters at bit 0 and migrates upward; LSB-first enters at the top.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] base,
                                                     input logic                  b);
    if (MSB_ORDER) return {base[DATA_WIDTH-2:0], b};
    else           return {b, base[DATA_WIDTH-1:1]};
  endfunction

  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] sh_shifted;
  logic [DATA_WIDTH-1:0] sync_seed;
  logic [CW-1:0]         cnt;
  logic                  word_done;

  hold_state_t hold_state;
  hold_state_t hold_state_next;
  logic        load_word;
  logic        drop_word;

  always_comb begin
    sh_shifted = shift_in(sh, i_data);
    sync_seed  = shift_in({DATA_WIDTH{1'b0}}, i_data);
  end

  // A completion coinciding with a frame restart is discarded.
  assign word_done = i_data_valid & ~i_sync & (cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (i_sync) begin
      sh  <= i_data_valid ? sync_seed : '0;
      cnt <= i_data_valid ? CW'(1) : '0;
    end else if (i_data_valid) begin
      sh  <= sh_shifted;
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Holding register: a read in the same cycle as a completion frees the slot
  // for the new word, so only an unread full slot loses data.
  always_comb begin
    hold_state_next = hold_state;
    load_word       = 1'b0;
    drop_word       = 1'b0;
    if (hold_state == EMPTY) begin
      if (word_done) begin
        hold_state_next = FULL;
        load_word       = 1'b1;
      end
    end else begin
      if (word_done && i_rd_en) begin
        load_word = 1'b1;
      end else if (word_done) begin
        drop_word = 1'b1;
      end else if (i_rd_en) begin
        hold_state_next = EMPTY;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      hold_state <= EMPTY;
      o_data     <= '0;
    end else begin
      hold_state <= hold_state_next;
      if (load_word) begin
        o_data <= sh_shifted;
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      o_overflow <= 1'b0;
    end else if (drop_word) begin
      o_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      o_overflow <= 1'b0;
    end
  end

  assign o_data_valid = (hold_state == FULL);

endmodule

// File: tb/tb_sipo.sv
// Bench for sipo: one MSB-first and one LSB-first instance, directed scenarios
// followed by a randomized serializer loopback against a bit-list reference model.
module tb_sipo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sync = 1'b0, dv = 1'b0, d_m = 1'b0, d_l = 1'b0, rd = 1'b0, clr = 1'b0;
  logic v_m, v_l, ov_m, ov_l;
  logic [7:0] q_m, q_l;

  sipo #(.DATA_WIDTH(8), .DO_MSB_FIRST("true")) dut_m (
    .i_clk(clk), .i_a_rst(rst), .i_sync(sync), .i_data_valid(dv), .i_data(d_m),
    .i_rd_en(rd), .i_clr_ovf(clr), .o_data_valid(v_m), .o_data(q_m), .o_overflow(ov_m)
  );

  sipo #(.DATA_WIDTH(8), .DO_MSB_FIRST("false")) dut_l (
    .i_clk(clk), .i_a_rst(rst), .i_sync(sync), .i_data_valid(dv), .i_data(d_l),
    .i_rd_en(rd), .i_clr_ovf(clr), .o_data_valid(v_l), .o_data(q_l), .o_overflow(ov_l)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, index 0 = MSB-first instance, 1 = LSB-first instance.
  bit         mb[2][8];
  int         mn[2];
  logic [7:0] md[2];
  logic       mv[2];
  logic       mo[2];

  logic [7:0] exp_q_m[$];
  logic [7:0] exp_q_l[$];
  bit         sb_on = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0;
      md[k] = 8'h00;
      mv[k] = 1'b0;
      mo[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic s, input logic v, input logic b,
                            input logic r, input logic c);
    logic [7:0] w;
    bit done;
    bit drop;
    done = 1'b0;
    w    = 8'h00;
    if (s) begin
      mn[k] = 0;
      if (v) begin
        mb[k][0] = b;
        mn[k]    = 1;
      end
    end else if (v) begin
      mb[k][mn[k]] = b;
      mn[k]++;
      if (mn[k] == 8) begin
        done  = 1'b1;
        mn[k] = 0;
        for (int i = 0; i < 8; i++)
          if (mb[k][i]) w[(k == 0) ? (7 - i) : i] = 1'b1;
      end
    end
    drop = done && mv[k] && !r;
    if (done && !drop) begin
      md[k] = w;
      mv[k] = 1'b1;
    end else if (!done && r) begin
      mv[k] = 1'b0;
    end
    if (drop) mo[k] = 1'b1;
    else if (c) mo[k] = 1'b0;
  endtask

  task automatic cycle(input logic s, input logic v, input logic bm, input logic bl,
                       input logic r, input logic c);
    logic [7:0] e;
    sync = s; dv = v; d_m = bm; d_l = bl; rd = r; clr = c;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(0, s, v, bm, r, c);
      model_step(1, s, v, bl, r, c);
    end
    #1;
    check("m_valid", 8'(v_m), 8'(mv[0]));
    check("m_data", q_m, md[0]);
    check("m_ovf", 8'(ov_m), 8'(mo[0]));
    check("l_valid", 8'(v_l), 8'(mv[1]));
    check("l_data", q_l, md[1]);
    check("l_ovf", 8'(ov_l), 8'(mo[1]));
    if (sb_on) begin
      if (v_m) begin
        check("sb_m_avail", 8'(exp_q_m.size() != 0), 8'd1);
        if (exp_q_m.size() != 0) begin
          e = exp_q_m.pop_front();
          check("sb_m_word", q_m, e);
        end
      end
      if (v_l) begin
        check("sb_l_avail", 8'(exp_q_l.size() != 0), 8'd1);
        if (exp_q_l.size() != 0) begin
          e = exp_q_l.pop_front();
          check("sb_l_word", q_l, e);
        end
      end
    end
  endtask

  // wm goes MSB-first into dut_m, wl goes LSB-first into dut_l.
  task automatic send_word(input logic [7:0] wm, input logic [7:0] wl, input int max_gap,
                           input logic rd_rest, input logic rd_last);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(max_gap, 0)) cycle(1'b0, 1'b0, 1'b0, 1'b0, rd_rest, 1'b0);
      cycle(1'b0, 1'b1, wm[7-i], wl[i], (i == 7) ? rd_last : rd_rest, 1'b0);
    end
  endtask

  task automatic read_out();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m_valid"}, 8'(v_m), 8'd0);
    check({tag, "_m_data"}, q_m, 8'h00);
    check({tag, "_m_ovf"}, 8'(ov_m), 8'd0);
    check({tag, "_l_valid"}, 8'(v_l), 8'd0);
    check({tag, "_l_data"}, q_l, 8'h00);
    check({tag, "_l_ovf"}, 8'(ov_l), 8'd0);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] wl;
    logic [7:0] seq[3];
    logic [7:0] w5a;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // MSB/LSB basic word 0xA5, then a read one cycle later
    send_word(8'hA5, 8'hA5, 0, 1'b0, 1'b0);
    check("a5_m_data", q_m, 8'hA5);
    check("a5_m_valid", 8'(v_m), 8'd1);
    check("a5_l_data", q_l, 8'hA5);
    read_out();
    check("a5_m_read", 8'(v_m), 8'd0);
    check("a5_l_read", 8'(v_l), 8'd0);

    // 0x3C with random gaps in the valid strobe
    send_word(8'h3C, 8'h3C, 3, 1'b0, 1'b0);
    check("3c_l_data", q_l, 8'h3C);
    check("3c_m_data", q_m, 8'h3C);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("3c_l_hold", q_l, 8'h3C);
    check("3c_l_valid", 8'(v_l), 8'd1);
    read_out();

    // full-rate words with the consumer always reading
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03;
    for (int n = 0; n < 3; n++) begin
      send_word(seq[n], seq[n], 0, 1'b1, 1'b1);
      check("fr_m_data", q_m, seq[n]);
      check("fr_l_data", q_l, seq[n]);
    end
    read_out();
    check("fr_m_ovf", 8'(ov_m), 8'd0);
    check("fr_l_ovf", 8'(ov_l), 8'd0);

    // overflow, clear, then completion coincident with read
    send_word(8'h11, 8'h11, 0, 1'b0, 1'b0);
    send_word(8'h22, 8'h22, 0, 1'b0, 1'b0);
    check("ovf_m_data", q_m, 8'h11);
    check("ovf_m_flag", 8'(ov_m), 8'd1);
    check("ovf_l_flag", 8'(ov_l), 8'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_m_flag", 8'(ov_m), 8'd0);
    check("clr_m_data", q_m, 8'h11);
    send_word(8'h33, 8'h33, 0, 1'b0, 1'b1);
    check("rdc_m_data", q_m, 8'h33);
    check("rdc_m_valid", 8'(v_m), 8'd1);
    check("rdc_m_ovf", 8'(ov_m), 8'd0);
    check("rdc_l_data", q_l, 8'h33);
    read_out();

    // frame restart after three garbage bits
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sync_m_data", q_m, 8'h80);
    check("sync_l_data", q_l, 8'h01);
    read_out();

    // async reset mid-word with a held word and overflow pending
    send_word(8'h77, 8'h77, 0, 1'b0, 1'b0);
    send_word(8'h66, 8'h66, 0, 1'b0, 1'b0);
    check("pre_rst_ovf", 8'(ov_m), 8'd1);
    w5a = 8'h5A;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, w5a[7-i], w5a[i], 1'b0, 1'b0);
    dv = 1'b0;
    rst = 1'b1;
    #2;
    check_zero("async_rst");
    model_reset();
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    send_word(8'h5A, 8'h5A, 0, 1'b0, 1'b0);
    check("post_rst_m", q_m, 8'h5A);
    check("post_rst_l", q_l, 8'h5A);
    read_out();

    // randomized serializer loopback, consumer always reading
    sb_on = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      w  = 8'($urandom_range(255, 0));
      wl = 8'($urandom_range(255, 0));
      exp_q_m.push_back(w);
      exp_q_l.push_back(wl);
      send_word(w, wl, 1, 1'b1, 1'b1);
    end
    repeat (3) read_out();
    sb_on = 1'b0;
    check("lb_m_left", 8'(exp_q_m.size()), 8'd0);
    check("lb_l_left", 8'(exp_q_l.size()), 8'd0);
    check("lb_m_ovf", 8'(ov_m), 8'd0);
    check("lb_l_ovf", 8'(ov_l), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
